// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one AXI4-Lite master port.
// A single transaction is in flight at a time. The request fields are latched
// when the grant is made, and the result is returned with a one-cycle ack.
module axi4_lite_master_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_BW = 32,
    parameter int unsigned DATA_BW = 32
) (
    input  logic                         i_clk,
    input  logic                         i_sync_rst,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ-1:0]             i_req_we,
    input  logic [N_REQ*ADDR_BW-1:0]     i_req_addr,
    input  logic [N_REQ*DATA_BW-1:0]     i_req_wdata,
    input  logic [N_REQ*DATA_BW/8-1:0]   i_req_wstrb,
    output logic [N_REQ-1:0]             o_req_ack,
    output logic [DATA_BW-1:0]           o_rsp_rdata,
    output logic [1:0]                   o_rsp_resp,
    output logic [ADDR_BW-1:0]           o_awaddr,
    output logic                         o_awvalid,
    input  logic                         i_awready,
    output logic [DATA_BW-1:0]           o_wdata,
    output logic [DATA_BW/8-1:0]         o_wstrb,
    output logic                         o_wvalid,
    input  logic                         i_wready,
    input  logic [1:0]                   i_bresp,
    input  logic                         i_bvalid,
    output logic                         o_bready,
    output logic [ADDR_BW-1:0]           o_araddr,
    output logic                         o_arvalid,
    input  logic                         i_arready,
    input  logic [DATA_BW-1:0]           i_rdata,
    input  logic [1:0]                   i_rresp,
    input  logic                         i_rvalid,
    output logic                         o_rready
);

    localparam int unsigned STRB_BW = DATA_BW / 8;
    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        ACK
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   gnt_q;      // current grantee, doubles as round-robin pointer

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand;
    logic               sel_we;
    logic [ADDR_BW-1:0] sel_addr;
    logic [DATA_BW-1:0] sel_wdata;
    logic [STRB_BW-1:0] sel_wstrb;
    logic               aw_done;
    logic               w_done;

    // Round-robin search starting one past the last grantee, then select its fields
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = PTR_W'((32'(gnt_q) + i) % N_REQ);
            if (!gnt_found && i_req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        sel_we    = i_req_we[gnt_idx];
        sel_addr  = i_req_addr[32'(gnt_idx) * ADDR_BW +: ADDR_BW];
        sel_wdata = i_req_wdata[32'(gnt_idx) * DATA_BW +: DATA_BW];
        sel_wstrb = i_req_wstrb[32'(gnt_idx) * STRB_BW +: STRB_BW];
    end

    // A write channel counts as done once its valid has dropped or is being accepted now
    assign aw_done = !o_awvalid || i_awready;
    assign w_done  = !o_wvalid  || i_wready;

    // Transaction sequencer with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_q     <= IDLE;
            gnt_q       <= PTR_W'(N_REQ - 1);
            o_req_ack   <= '0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= 2'b00;
            o_awaddr    <= '0;
            o_awvalid   <= 1'b0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
            o_wvalid    <= 1'b0;
            o_bready    <= 1'b0;
            o_araddr    <= '0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q <= gnt_idx;
                        if (sel_we) begin
                            o_awaddr  <= sel_addr;
                            o_wdata   <= sel_wdata;
                            o_wstrb   <= sel_wstrb;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            o_araddr  <= sel_addr;
                            o_arvalid <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (o_awvalid && i_awready) begin
                        o_awvalid <= 1'b0;
                    end
                    if (o_wvalid && i_wready) begin
                        o_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        o_bready <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (i_bvalid) begin
                        o_bready    <= 1'b0;
                        o_rsp_resp  <= i_bresp;
                        o_rsp_rdata <= '0;
                        o_req_ack   <= N_REQ'(1) << gnt_q;
                        state_q     <= ACK;
                    end
                end
                RD_REQ: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (i_rvalid) begin
                        o_rready    <= 1'b0;
                        o_rsp_rdata <= i_rdata;
                        o_rsp_resp  <= i_rresp;
                        o_req_ack   <= N_REQ'(1) << gnt_q;
                        state_q     <= ACK;
                    end
                end
                ACK: begin
                    o_req_ack <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
